door_game_ctrl: RTL and testbench

- Parametrised round controller for the door-guessing game. Supersedes the tied-off constants (lives, correct door, time_up) that currently feed screen_drawer.
- Generalised to NUM_PLAYERS players and NUM_DOORS doors.
- Runs the round timer, picks the correct door pseudo-randomly, moves players, deducts lives and detects game over/winner.
- Sits between the input debouncers/serial decoder and screen_drawer, clocked on the VGA pixel clock.

---
 rtl/door_game_pkg.sv | 21 ++
 rtl/door_game_ctrl_if.sv | 41 ++++
 rtl/door_lfsr.sv | 31 +++
 rtl/door_game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_door_game_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/door_game_pkg.sv
// Shared types and constants for the door-guessing round controller.
package door_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    REVEAL,
    CHECK,
    GAME_OVER
  } state_t;

  localparam int unsigned LIFE_W  = 2;
  localparam int unsigned LFSR_W  = 8;
  localparam int unsigned TIMER_W = 32;
  localparam int unsigned ROUND_W = 8;

  // Fibonacci feedback taps 8,6,5,4 (bit positions 7,5,4,3).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/door_game_ctrl_if.sv
// Control/status bundle between the input front-end, the round controller
// and screen_drawer.
//   start, move_left, move_right : requests into the controller (pulses)
//   player_pos, lives            : packed per-player state, player 0 in LSBs
//   correct_door, time_up        : current round door and reveal flag
//   round_num, game_over         : rounds completed and end-of-game flag
//   winner, winner_valid         : sole survivor index and validity
interface door_game_ctrl_if
  import door_game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_DOORS   = 4
);

  localparam int unsigned DOOR_W = $clog2(NUM_DOORS);

  logic                          start;
  logic [NUM_PLAYERS-1:0]        move_left;
  logic [NUM_PLAYERS-1:0]        move_right;
  logic [NUM_PLAYERS*DOOR_W-1:0] player_pos;
  logic [NUM_PLAYERS*LIFE_W-1:0] lives;
  logic [DOOR_W-1:0]             correct_door;
  logic                          time_up;
  logic [ROUND_W-1:0]            round_num;
  logic                          game_over;
  logic [1:0]                    winner;
  logic                          winner_valid;

  modport master (
    output start, move_left, move_right,
    input  player_pos, lives, correct_door, time_up, round_num,
           game_over, winner, winner_valid
  );

  modport slave (
    input  start, move_left, move_right,
    output player_pos, lives, correct_door, time_up, round_num,
           game_over, winner, winner_valid
  );

endinterface

// File: rtl/door_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the correct door each round.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   en         : advance one step per cycle when high
//   value      : current register contents
module door_lfsr
  import door_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // Shift left, feedback is the parity of the tapped bits.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/door_game_ctrl.sv
// Round controller for the door-guessing game: runs the round/reveal timer,
// picks the correct door, moves players, deducts lives and detects game over.
//   clk, reset_n : pixel clock, async active-low reset
//   bus          : slave side of door_game_ctrl_if (requests in, state out)
module door_game_ctrl
  import door_game_pkg::*;
#(
  parameter int unsigned       NUM_PLAYERS  = 2,
  parameter int unsigned       NUM_DOORS    = 4,
  parameter int unsigned       LIVES        = 3,
  parameter int unsigned       ROUND_TICKS  = 25_000_000,
  parameter int unsigned       REVEAL_TICKS = 12_500_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset_n,
  door_game_ctrl_if.slave bus
);

  localparam int unsigned DOOR_W = $clog2(NUM_DOORS);
  localparam int unsigned CNT_W  = 3;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [DOOR_W-1:0]    door_q, door_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 time_up_q, time_up_d;
  logic                 game_over_q, game_over_d;
  logic [1:0]           winner_q, winner_d;
  logic                 winner_valid_q, winner_valid_d;
  logic [LFSR_W-1:0]    lfsr_value;
  logic [NUM_PLAYERS-1:0] alive_nxt;
  logic [CNT_W-1:0]     alive_cnt;
  logic [1:0]           win_idx;
  logic                 game_end;

  door_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(reset_n),
    .en   (1'b1),
    .value(lfsr_value)
  );

  // Per-player position and lives.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [DOOR_W-1:0] pos_q, pos_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic              alive;

    assign alive = (lives_q != '0);

    always_comb begin
      pos_d   = pos_q;
      lives_d = lives_q;
      if (state_q == LOAD) begin
        pos_d = '0;
      end else if (state_q == ROUND && alive) begin
        // Opposing requests in the same cycle cancel out.
        if (bus.move_right[p] && !bus.move_left[p] &&
            pos_q != DOOR_W'(NUM_DOORS - 1))
          pos_d = pos_q + DOOR_W'(1);
        else if (bus.move_left[p] && !bus.move_right[p] && pos_q != '0)
          pos_d = pos_q - DOOR_W'(1);
      end
      if (state_q == CHECK && alive && pos_q != door_q)
        lives_d = lives_q - LIFE_W'(1);
      else if (state_q == GAME_OVER && bus.start)
        lives_d = LIFE_W'(LIVES);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_q   <= '0;
        lives_q <= LIFE_W'(LIVES);
      end else begin
        pos_q   <= pos_d;
        lives_q <= lives_d;
      end
    end

    assign alive_nxt[p] = (lives_d != '0);
    assign bus.player_pos[p*DOOR_W +: DOOR_W] = pos_q;
    assign bus.lives[p*LIFE_W +: LIFE_W]      = lives_q;
  end

  // Post-deduction survivor count and index (only meaningful in CHECK).
  always_comb begin
    alive_cnt = '0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (alive_nxt[i]) begin
        alive_cnt = alive_cnt + CNT_W'(1);
        win_idx   = 2'(i);
      end
    end
  end

  assign game_end = (NUM_PLAYERS > 1) ? (alive_cnt <= CNT_W'(1))
                                      : (alive_cnt == '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    door_d         = door_q;
    round_d        = round_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: begin
        door_d  = DOOR_W'(32'(lfsr_value) % NUM_DOORS);
        timer_d = TIMER_W'(ROUND_TICKS - 1);
        state_d = ROUND;
      end
      ROUND: begin
        if (timer_q == '0) begin
          timer_d = TIMER_W'(REVEAL_TICKS - 1);
          state_d = REVEAL;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      REVEAL: begin
        if (timer_q == '0) state_d = CHECK;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      CHECK: begin
        if (round_q != '1) round_d = round_q + ROUND_W'(1);
        if (game_end) begin
          state_d        = GAME_OVER;
          winner_valid_d = (alive_cnt == CNT_W'(1));
          winner_d       = (alive_cnt == CNT_W'(1)) ? win_idx : 2'd0;
        end else begin
          state_d = LOAD;
        end
      end
      GAME_OVER: begin
        if (bus.start) begin
          round_d = '0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    time_up_d   = (state_d == REVEAL);
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      door_q         <= '0;
      round_q        <= '0;
      time_up_q      <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      door_q         <= door_d;
      round_q        <= round_d;
      time_up_q      <= time_up_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
    end
  end

  assign bus.correct_door = door_q;
  assign bus.time_up      = time_up_q;
  assign bus.round_num    = round_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;

endmodule

// File: tb/tb_door_game_ctrl.sv
// Directed bench for door_game_ctrl: a 2-player/4-door instance (a) and a
// 3-player/8-door instance (b), both with 8-cycle rounds and 4-cycle reveals.
module tb_door_game_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  door_game_ctrl_if #(.NUM_PLAYERS(2), .NUM_DOORS(4)) bus_a ();
  door_game_ctrl_if #(.NUM_PLAYERS(3), .NUM_DOORS(8)) bus_b ();

  door_game_ctrl #(
    .NUM_PLAYERS(2), .NUM_DOORS(4), .LIVES(3),
    .ROUND_TICKS(8), .REVEAL_TICKS(4), .LFSR_SEED(8'hA5)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a.slave));

  door_game_ctrl #(
    .NUM_PLAYERS(3), .NUM_DOORS(8), .LIVES(3),
    .ROUND_TICKS(8), .REVEAL_TICKS(4), .LFSR_SEED(8'hA5)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifted left, seeded on reset.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int n_chk = 0;
  int n_bad = 0;
  int exp_lives [3];
  int exp_round;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rd_pos(input bit s, input int p);
    if (s) return int'(bus_b.player_pos[p*3 +: 3]);
    return int'(bus_a.player_pos[p*2 +: 2]);
  endfunction
  function automatic int rd_lives(input bit s, input int p);
    if (s) return int'(bus_b.lives[p*2 +: 2]);
    return int'(bus_a.lives[p*2 +: 2]);
  endfunction
  function automatic int rd_lives_all(input bit s);
    return s ? int'(bus_b.lives) : int'(bus_a.lives);
  endfunction
  function automatic int rd_door(input bit s);
    return s ? int'(bus_b.correct_door) : int'(bus_a.correct_door);
  endfunction
  function automatic int rd_tu(input bit s);
    return s ? int'(bus_b.time_up) : int'(bus_a.time_up);
  endfunction
  function automatic int rd_round(input bit s);
    return s ? int'(bus_b.round_num) : int'(bus_a.round_num);
  endfunction
  function automatic int rd_go(input bit s);
    return s ? int'(bus_b.game_over) : int'(bus_a.game_over);
  endfunction
  function automatic int rd_win(input bit s);
    return s ? int'(bus_b.winner) : int'(bus_a.winner);
  endfunction
  function automatic int rd_wv(input bit s);
    return s ? int'(bus_b.winner_valid) : int'(bus_a.winner_valid);
  endfunction
  function automatic int m_door(input int nd);
    return int'(m_lfsr) % nd;
  endfunction

  task automatic drive(input bit s, input logic st, input logic [2:0] l, input logic [2:0] r);
    if (s) begin
      bus_b.start = st; bus_b.move_left = l; bus_b.move_right = r;
    end else begin
      bus_a.start = st; bus_a.move_left = l[1:0]; bus_a.move_right = r[1:0];
    end
  endtask

  task automatic chk_reset(input bit s);
    int np;
    np = s ? 3 : 2;
    for (int p = 0; p < np; p++) begin
      check("rst_pos", rd_pos(s, p), 0);
      check("rst_lives", rd_lives(s, p), 3);
    end
    check("rst_door", rd_door(s), 0);
    check("rst_time_up", rd_tu(s), 0);
    check("rst_round", rd_round(s), 0);
    check("rst_game_over", rd_go(s), 0);
    check("rst_winner", rd_win(s), 0);
    check("rst_winner_valid", rd_wv(s), 0);
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 3'b0, 3'b0);
    drive(1, 1'b0, 3'b0, 3'b0);
    reset_n = 1'b0;
    repeat (2) tick();
    chk_reset(0);
    chk_reset(1);
    reset_n = 1'b1;
    tick();
  endtask

  // Pulse start from IDLE or GAME_OVER; returns with the DUT in LOAD.
  task automatic start_game(input bit s);
    drive(s, 1'b1, 3'b0, 3'b0);
    tick();
    drive(s, 1'b0, 3'b0, 3'b0);
    exp_round = 0;
    for (int p = 0; p < 3; p++) exp_lives[p] = 3;
    check("start_round", rd_round(s), 0);
    check("start_lives", rd_lives_all(s), s ? 63 : 15);
    check("start_game_over", rd_go(s), 0);
    check("start_time_up", rd_tu(s), 0);
  endtask

  // One full round from LOAD: pr* right presses per player (both[p] presses
  // left and right together every cycle), then reveal and life deduction.
  task automatic do_round(input bit s, input int pr0, input int pr1, input int pr2,
                          input logic [2:0] both);
    int np, nd, door, alive_n;
    int pr [3];
    int pos [3];
    logic [2:0] l, r;
    np = s ? 3 : 2;
    nd = s ? 8 : 4;
    pr = '{pr0, pr1, pr2};
    door = m_door(nd);
    tick();
    check("door", rd_door(s), door);
    for (int p = 0; p < 3; p++) pos[p] = 0;
    for (int k = 0; k < 8; k++) begin
      l = '0;
      r = '0;
      for (int p = 0; p < np; p++) begin
        if (both[p]) begin
          l[p] = 1'b1; r[p] = 1'b1;
        end else if (k < pr[p]) begin
          r[p] = 1'b1;
        end
      end
      // A stray start mid-round must be ignored.
      drive(s, k == 3, l, r);
      tick();
      for (int p = 0; p < np; p++) begin
        if (exp_lives[p] > 0 && r[p] && !l[p] && pos[p] < nd - 1) pos[p]++;
        if (exp_lives[p] > 0) check("pos", rd_pos(s, p), pos[p]);
      end
      if (k == 6) check("time_up_early", rd_tu(s), 0);
    end
    drive(s, 1'b0, 3'b0, 3'b0);
    check("time_up_rise", rd_tu(s), 1);
    repeat (3) begin
      tick();
      check("time_up_hold", rd_tu(s), 1);
    end
    tick();
    check("time_up_fall", rd_tu(s), 0);
    for (int p = 0; p < np; p++) check("lives_pre", rd_lives(s, p), exp_lives[p]);
    tick();
    alive_n = 0;
    for (int p = 0; p < np; p++) begin
      if (exp_lives[p] > 0 && pos[p] != door) exp_lives[p]--;
      if (exp_lives[p] > 0) alive_n++;
      check("lives_post", rd_lives(s, p), exp_lives[p]);
    end
    if (exp_round < 255) exp_round++;
    check("round_num", rd_round(s), exp_round);
    check("game_over", rd_go(s), (alive_n <= 1) ? 1 : 0);
  endtask

  initial begin
    int d;
    reset_n = 1'b0;
    do_reset();

    // No start: stays idle.
    repeat (5) tick();
    check("idle_time_up", rd_tu(0), 0);
    check("idle_round", rd_round(0), 0);

    // Saturating moves for P0, cancelled moves for P1.
    start_game(0);
    do_round(0, 5, 0, 0, 3'b010);

    // P1 always one door off: eliminated after three rounds, P0 wins.
    do_reset();
    start_game(0);
    for (int i = 0; i < 3; i++) begin
      d = m_door(4);
      do_round(0, d, (d + 1) % 4, 0, 3'b000);
    end
    check("b_game_over", rd_go(0), 1);
    check("b_winner", rd_win(0), 0);
    check("b_winner_valid", rd_wv(0), 1);
    check("b_round", rd_round(0), 3);

    // Restart from GAME_OVER; both always wrong: draw.
    start_game(0);
    for (int i = 0; i < 3; i++) begin
      d = m_door(4);
      do_round(0, (d + 1) % 4, (d + 2) % 4, 0, 3'b000);
    end
    check("c_game_over", rd_go(0), 1);
    check("c_winner_valid", rd_wv(0), 0);
    check("c_lives", rd_lives_all(0), 0);
    check("c_round", rd_round(0), 3);

    // Reset asserted during REVEAL.
    do_reset();
    start_game(0);
    repeat (10) tick();
    check("d_in_reveal", rd_tu(0), 1);
    reset_n = 1'b0;
    #1;
    chk_reset(0);
    #2;
    reset_n = 1'b1;
    repeat (20) tick();
    check("d_lives_kept", rd_lives_all(0), 15);
    check("d_time_up_idle", rd_tu(0), 0);
    check("d_round_idle", rd_round(0), 0);

    // 3 players, 8 doors: 50 clean rounds, then P2 out, then P1 out.
    start_game(1);
    for (int i = 0; i < 50; i++) begin
      d = m_door(8);
      do_round(1, d, d, d, 3'b000);
    end
    for (int i = 0; i < 3; i++) begin
      d = m_door(8);
      do_round(1, d, d, (d + 3) % 8, 3'b000);
    end
    check("e_alive2_running", rd_go(1), 0);
    check("e_lives_mixed", rd_lives_all(1), 6'b00_11_11);
    for (int i = 0; i < 3; i++) begin
      d = m_door(8);
      do_round(1, d, (d + 1) % 8, 0, 3'b000);
    end
    check("e_game_over", rd_go(1), 1);
    check("e_winner", rd_win(1), 0);
    check("e_winner_valid", rd_wv(1), 1);
    check("e_round", rd_round(1), 56);
    start_game(1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
